// File: rtl/servo_pkg.sv
// Shared definitions for the shutter servo controller: per-channel FSM
// state encoding, direction constants, default servo position codes and
// the pulse-width helper used by the PWM generator.
package servo_pkg;

  typedef logic state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t DRIVE = 1'b1;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  localparam logic [7:0] POS_UP_DEF   = 8'hFF;
  localparam logic [7:0] POS_HALT_DEF = 8'h50;
  localparam logic [7:0] POS_DOWN_DEF = 8'h0F;

  // Pulse width in clk_50 cycles for a given position code.
  function automatic logic [31:0] pulse_limit(input logic [7:0]  pos,
                                              input logic [31:0] pmin,
                                              input logic [31:0] pstep);
    return pmin + ({24'd0, pos} * pstep);
  endfunction

endpackage

// File: rtl/servo_shutter_array_if.sv
// Bundle between the system sequencer and the shutter controller.
//   direct : per-channel requested direction level (1 = up, 0 = down)
//   pwm    : servo pulse train per channel
//   busy   : channel is driving
//   done   : one-cycle pulse when a drive window completes
//   at_up  : last commanded direction per channel
// master = sequencer side, slave = controller side.
interface servo_shutter_array_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0] direct;
  logic [N_CH-1:0] pwm;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] done;
  logic [N_CH-1:0] at_up;

  modport master (output direct, input pwm, busy, done, at_up);
  modport slave  (input direct, output pwm, busy, done, at_up);
endinterface

// File: rtl/servo_pwm_ch.sv
// Single-channel servo pulse generator.
//   clk_50 : system clock
//   reset  : asynchronous, active-high
//   pos    : commanded position code
//   pwm    : pulse train, one pulse per frame
// The position is sampled only at the start of a frame so a command change
// never truncates or stretches a pulse already in progress.
module servo_pwm_ch
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYC  = 1000000,
  parameter int unsigned PULSE_MIN  = 50000,
  parameter int unsigned PULSE_STEP = 195
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [7:0] pos,
  output logic       pwm
);

  localparam int FW = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYC - 1);

  logic [FW-1:0] r_frame_cnt;
  logic [7:0]    r_pos_lat;
  logic          r_pwm;
  logic          w_frame_start;
  logic [7:0]    w_pos_eff;
  logic [31:0]   w_limit;

  // At frame start the fresh command is used directly, so the pulse that
  // begins on that cycle already reflects the newly latched position.
  assign w_frame_start = (r_frame_cnt == '0);
  assign w_pos_eff     = w_frame_start ? pos : r_pos_lat;
  assign w_limit       = pulse_limit(w_pos_eff, 32'(PULSE_MIN), 32'(PULSE_STEP));

  // pwm is registered so it is low during reset; it trails frame_cnt by one
  // cycle, which keeps the pulse width exact.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_pos_lat   <= POS_HALT_DEF;
      r_pwm       <= 1'b0;
    end else begin
      r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + 1'b1;
      if (w_frame_start) r_pos_lat <= pos;
      r_pwm <= (32'(r_frame_cnt) < w_limit);
    end
  end

  assign pwm = r_pwm;

endmodule

// File: rtl/servo_shutter_array.sv
// N-channel shutter servo controller.
//   clk_50 : system clock (only clock)
//   reset  : asynchronous, active-high
//   bus    : slave side of servo_shutter_array_if (direct in; pwm, busy,
//            done, at_up out)
// Each channel watches its synchronised direction level; on a change it
// drives the servo toward the new direction for DRIVE_MS ms ticks, then
// returns to the halt position.
//
// state | meaning
// IDLE  | servo at halt, waiting for dir_s to differ from last_dir
// DRIVE | servo driven up/down, counting ms ticks up to DRIVE_MS
module servo_shutter_array
  import servo_pkg::*;
#(
  parameter int               N_CH       = 2,
  parameter int unsigned      TICK_DIV   = 50000,
  parameter int               CNT_W      = 12,
  parameter logic [CNT_W-1:0] DRIVE_MS   = CNT_W'(4),
  parameter logic [7:0]       POS_UP     = POS_UP_DEF,
  parameter logic [7:0]       POS_HALT   = POS_HALT_DEF,
  parameter logic [7:0]       POS_DOWN   = POS_DOWN_DEF,
  parameter bit               ABORT_REV  = 1'b0,
  parameter int unsigned      FRAME_CYC  = 1000000,
  parameter int unsigned      PULSE_MIN  = 50000,
  parameter int unsigned      PULSE_STEP = 195
) (
  input  logic                  clk_50,
  input  logic                  reset,
  servo_shutter_array_if.slave  bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [TW-1:0]   r_tick_cnt;
  logic            w_tick;

  logic [N_CH-1:0] w_pwm;
  logic [N_CH-1:0] w_busy;
  logic [N_CH-1:0] w_done;
  logic [N_CH-1:0] w_at_up;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.direct;
      r_sync2 <= r_sync1;
    end
  end

  // Shared ms prescaler; every channel counts the same tick.
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) r_tick_cnt <= '0;
    else       r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic             r_last_dir, w_last_dir_nxt;
    logic             r_done, w_done_nxt;
    logic [7:0]       r_pos_cmd, w_pos_nxt;
    logic [CNT_W-1:0] r_drive_cnt, w_cnt_nxt;
    logic             w_dir_s;
    logic             w_rev;
    logic             w_busy_ch, w_done_ch, w_at_up_ch;

    assign w_dir_s = r_sync2[g];
    assign w_rev   = (w_dir_s != r_last_dir);

    always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
        r_state     <= IDLE;
        r_last_dir  <= 1'b0;
        r_done      <= 1'b0;
        r_pos_cmd   <= POS_HALT;
        r_drive_cnt <= '0;
      end else begin
        r_state     <= w_state_nxt;
        r_last_dir  <= w_last_dir_nxt;
        r_done      <= w_done_nxt;
        r_pos_cmd   <= w_pos_nxt;
        r_drive_cnt <= w_cnt_nxt;
      end
    end

    // Entering (or re-entering) DRIVE clears the counter, so a tick that
    // lands on the entry cycle is dropped. An abort-reversal outranks the
    // completion check, so an aborted window never reports done.
    always_comb begin
      w_state_nxt    = r_state;
      w_last_dir_nxt = r_last_dir;
      w_pos_nxt      = r_pos_cmd;
      w_cnt_nxt      = r_drive_cnt;
      w_done_nxt     = 1'b0;
      if (r_state == IDLE) begin
        if (w_rev) begin
          w_state_nxt    = DRIVE;
          w_pos_nxt      = (w_dir_s == UP) ? POS_UP : POS_DOWN;
          w_last_dir_nxt = w_dir_s;
          w_cnt_nxt      = '0;
        end else begin
          w_pos_nxt = POS_HALT;
        end
      end else begin
        if (ABORT_REV && w_rev) begin
          w_pos_nxt      = (w_dir_s == UP) ? POS_UP : POS_DOWN;
          w_last_dir_nxt = w_dir_s;
          w_cnt_nxt      = '0;
        end else if (r_drive_cnt == DRIVE_MS) begin
          w_state_nxt = IDLE;
          w_pos_nxt   = POS_HALT;
          w_done_nxt  = 1'b1;
        end else if (w_tick) begin
          w_cnt_nxt = r_drive_cnt + 1'b1;
        end
      end
    end

    always_comb begin
      w_busy_ch  = (r_state == DRIVE);
      w_done_ch  = r_done;
      w_at_up_ch = r_last_dir;
    end

    servo_pwm_ch #(
      .FRAME_CYC  (FRAME_CYC),
      .PULSE_MIN  (PULSE_MIN),
      .PULSE_STEP (PULSE_STEP)
    ) u_pwm (
      .clk_50 (clk_50),
      .reset  (reset),
      .pos    (r_pos_cmd),
      .pwm    (w_pwm[g])
    );

    assign w_busy[g]  = w_busy_ch;
    assign w_done[g]  = w_done_ch;
    assign w_at_up[g] = w_at_up_ch;
  end

  assign bus.pwm   = w_pwm;
  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.at_up = w_at_up;

endmodule

// File: tb/tb_servo_shutter_array.sv
// Directed bench for servo_shutter_array with shortened timing.
// dut0 queues reversals, dut1 aborts and reverses; both see the same
// direction inputs and reset.
module tb_servo_shutter_array;

  logic       clk_50 = 1'b0;
  logic       reset  = 1'b1;
  logic [1:0] direct = 2'b00;

  int total = 0;
  int bad   = 0;

  always #5 clk_50 = ~clk_50;

  servo_shutter_array_if #(.N_CH(2)) bus0 ();
  servo_shutter_array_if #(.N_CH(2)) bus1 ();

  assign bus0.direct = direct;
  assign bus1.direct = direct;

  servo_shutter_array #(
    .N_CH(2), .TICK_DIV(10), .CNT_W(12), .DRIVE_MS(12'd4),
    .ABORT_REV(1'b0), .FRAME_CYC(400), .PULSE_MIN(20), .PULSE_STEP(1)
  ) dut0 (.clk_50(clk_50), .reset(reset), .bus(bus0));

  servo_shutter_array #(
    .N_CH(2), .TICK_DIV(10), .CNT_W(12), .DRIVE_MS(12'd4),
    .ABORT_REV(1'b1), .FRAME_CYC(400), .PULSE_MIN(20), .PULSE_STEP(1)
  ) dut1 (.clk_50(clk_50), .reset(reset), .bus(bus1));

  // pulse monitor on dut0 channel 0, done counters for both duts
  int   mon_cyc = 0, last_rise_cyc = 0, mon_period = 0, mon_width = 0, mon_run = 0;
  int   pulse_cnt = 0, rise_cnt = 0;
  logic mon_prev = 1'b0;
  int   dc0 [2] = '{0, 0};
  int   dc1 [2] = '{0, 0};

  always @(negedge clk_50) begin
    mon_cyc++;
    if (reset) begin
      mon_prev = 1'b0;
      mon_run  = 0;
    end else begin
      if (bus0.pwm[0]) mon_run++;
      if (bus0.pwm[0] && !mon_prev) begin
        rise_cnt++;
        mon_period    = mon_cyc - last_rise_cyc;
        last_rise_cyc = mon_cyc;
      end
      if (!bus0.pwm[0] && mon_prev) begin
        mon_width = mon_run;
        mon_run   = 0;
        pulse_cnt++;
      end
      mon_prev = bus0.pwm[0];
      for (int c = 0; c < 2; c++) begin
        if (bus0.done[c]) dc0[c]++;
        if (bus1.done[c]) dc1[c]++;
      end
    end
  end

  task automatic step();
    @(negedge clk_50);
    #1;
  endtask

  task automatic test_reset();
    int p0, r0;
    reset = 1'b1;
    direct = 2'b00;
    repeat (5) step();
    total++; if (bus0.pwm !== 2'b00) begin bad++; $display("FAIL reset_pwm got=%b want=00", bus0.pwm); end
    total++; if (bus0.busy !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b want=00", bus0.busy); end
    total++; if (bus0.done !== 2'b00) begin bad++; $display("FAIL reset_done got=%b want=00", bus0.done); end
    total++; if (bus0.at_up !== 2'b00) begin bad++; $display("FAIL reset_at_up got=%b want=00", bus0.at_up); end
    reset = 1'b0;
    p0 = pulse_cnt;
    for (int i = 0; i < 1000 && pulse_cnt == p0; i++) step();
    total++; if (pulse_cnt == p0) begin bad++; $display("FAIL reset_pulse_timeout got=none want=pulse"); end
    total++; if (mon_width !== 100) begin bad++; $display("FAIL reset_halt_width got=%0d want=100", mon_width); end
    r0 = rise_cnt;
    for (int i = 0; i < 1000 && rise_cnt == r0; i++) step();
    total++; if (mon_period !== 400) begin bad++; $display("FAIL reset_frame_len got=%0d want=400", mon_period); end
  endtask

  task automatic test_up_drive();
    int r0, p0, d0, blen;
    r0 = rise_cnt;
    for (int i = 0; i < 500 && rise_cnt == r0; i++) step();
    // place the next frame boundary inside the drive window
    repeat (380) step();
    p0 = pulse_cnt;
    d0 = dc0[0];
    direct[0] = 1'b1;
    repeat (2) step();
    total++; if (bus0.busy[0] !== 1'b0) begin bad++; $display("FAIL up_busy_early got=%b want=0", bus0.busy[0]); end
    step();
    total++; if (bus0.busy[0] !== 1'b1) begin bad++; $display("FAIL up_busy_lat3 got=%b want=1", bus0.busy[0]); end
    total++; if (bus0.at_up[0] !== 1'b1) begin bad++; $display("FAIL up_at_up got=%b want=1", bus0.at_up[0]); end
    blen = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus0.busy[0]) blen++;
      else break;
    end
    // window spans 31..40 cycles of counting plus the cycle spent at the saturated count
    total++; if (blen < 31 || blen > 41) begin bad++; $display("FAIL up_busy_len got=%0d want=31..41", blen); end
    total++; if (bus0.done[0] !== 1'b1) begin bad++; $display("FAIL up_done_edge got=%b want=1", bus0.done[0]); end
    step();
    total++; if (dc0[0] - d0 !== 1) begin bad++; $display("FAIL up_done_count got=%0d want=1", dc0[0] - d0); end
    for (int i = 0; i < 800 && pulse_cnt == p0; i++) step();
    total++; if (mon_width !== 275) begin bad++; $display("FAIL up_pwm_width got=%0d want=275", mon_width); end
    p0 = pulse_cnt;
    for (int i = 0; i < 800 && pulse_cnt == p0; i++) step();
    total++; if (mon_width !== 100) begin bad++; $display("FAIL up_pwm_halt got=%0d want=100", mon_width); end
  endtask

  task automatic test_repeat_level();
    int p0, d0, bc;
    p0 = pulse_cnt;
    d0 = dc0[0];
    bc = 0;
    for (int i = 0; i < 450; i++) begin
      step();
      if (bus0.busy[0]) bc++;
    end
    total++; if (bc !== 0) begin bad++; $display("FAIL repeat_busy got=%0d want=0", bc); end
    total++; if (dc0[0] !== d0) begin bad++; $display("FAIL repeat_done got=%0d want=%0d", dc0[0], d0); end
    total++; if (pulse_cnt == p0) begin bad++; $display("FAIL repeat_pulse_timeout got=none want=pulse"); end
    total++; if (mon_width !== 100) begin bad++; $display("FAIL repeat_width got=%0d want=100", mon_width); end
    total++; if (bus0.at_up[0] !== 1'b1) begin bad++; $display("FAIL repeat_at_up got=%b want=1", bus0.at_up[0]); end
  endtask

  task automatic test_reversal();
    int r0, p0, d0, d1;
    direct[0] = 1'b0;
    d0 = dc0[0];
    for (int i = 0; i < 100 && dc0[0] == d0; i++) step();
    total++; if (dc0[0] == d0) begin bad++; $display("FAIL rev_pre_done got=none want=done"); end
    r0 = rise_cnt;
    for (int i = 0; i < 500 && rise_cnt == r0; i++) step();
    // up window ends late enough that the queued down drive spans the frame start
    repeat (350) step();
    p0 = pulse_cnt;
    d0 = dc0[0];
    d1 = dc1[0];
    direct[0] = 1'b1;
    repeat (3) step();
    total++; if (bus0.busy[0] !== 1'b1) begin bad++; $display("FAIL rev_busy_q got=%b want=1", bus0.busy[0]); end
    total++; if (bus1.busy[0] !== 1'b1) begin bad++; $display("FAIL rev_busy_a got=%b want=1", bus1.busy[0]); end
    repeat (15) step();
    direct[0] = 1'b0;
    repeat (2) step();
    total++; if (bus1.at_up[0] !== 1'b1) begin bad++; $display("FAIL abort_at_up_hold got=%b want=1", bus1.at_up[0]); end
    step();
    total++; if (bus1.at_up[0] !== 1'b0) begin bad++; $display("FAIL abort_at_up_flip got=%b want=0", bus1.at_up[0]); end
    total++; if (bus1.busy[0] !== 1'b1) begin bad++; $display("FAIL abort_busy got=%b want=1", bus1.busy[0]); end
    for (int i = 0; i < 80 && !bus0.done[0]; i++) step();
    total++; if (bus0.done[0] !== 1'b1) begin bad++; $display("FAIL queued_done got=%b want=1", bus0.done[0]); end
    total++; if (bus0.busy[0] !== 1'b0) begin bad++; $display("FAIL queued_idle got=%b want=0", bus0.busy[0]); end
    total++; if (bus0.at_up[0] !== 1'b1) begin bad++; $display("FAIL queued_at_up_hold got=%b want=1", bus0.at_up[0]); end
    total++; if (dc1[0] !== d1) begin bad++; $display("FAIL abort_no_done got=%0d want=%0d", dc1[0], d1); end
    total++; if (bus1.busy[0] !== 1'b1) begin bad++; $display("FAIL abort_still_busy got=%b want=1", bus1.busy[0]); end
    step();
    total++; if (bus0.busy[0] !== 1'b1) begin bad++; $display("FAIL queued_restart got=%b want=1", bus0.busy[0]); end
    total++; if (bus0.at_up[0] !== 1'b0) begin bad++; $display("FAIL queued_at_up_down got=%b want=0", bus0.at_up[0]); end
    total++; if (dc0[0] - d0 !== 1) begin bad++; $display("FAIL queued_done_count got=%0d want=1", dc0[0] - d0); end
    for (int i = 0; i < 800 && pulse_cnt == p0; i++) step();
    total++; if (mon_width !== 35) begin bad++; $display("FAIL rev_pwm_down got=%0d want=35", mon_width); end
    for (int i = 0; i < 100 && (bus0.busy[0] || bus1.busy[0]); i++) step();
    total++; if ({bus0.busy[0], bus1.busy[0]} !== 2'b00) begin bad++; $display("FAIL rev_settle got=%b want=00", {bus0.busy[0], bus1.busy[0]}); end
  endtask

  task automatic test_two_channels();
    int d0;
    direct[1] = 1'b1;
    d0 = dc0[1];
    for (int i = 0; i < 100 && dc0[1] == d0; i++) step();
    total++; if (dc0[1] == d0) begin bad++; $display("FAIL two_pre_done got=none want=done"); end
    repeat (3) step();
    direct = 2'b01;
    repeat (2) step();
    total++; if (bus0.busy !== 2'b00) begin bad++; $display("FAIL two_busy_early got=%b want=00", bus0.busy); end
    step();
    total++; if (bus0.busy !== 2'b11) begin bad++; $display("FAIL two_busy_same got=%b want=11", bus0.busy); end
    total++; if (bus0.at_up !== 2'b01) begin bad++; $display("FAIL two_at_up got=%b want=01", bus0.at_up); end
    for (int i = 0; i < 80 && bus0.done == 2'b00; i++) step();
    total++; if (bus0.done !== 2'b11) begin bad++; $display("FAIL two_done_same got=%b want=11", bus0.done); end
    total++; if (bus0.busy !== 2'b00) begin bad++; $display("FAIL two_idle got=%b want=00", bus0.busy); end
  endtask

  task automatic test_reset_mid_drive();
    int r0, d0;
    r0 = rise_cnt;
    for (int i = 0; i < 500 && rise_cnt == r0; i++) step();
    direct = 2'b11;
    repeat (3) step();
    total++; if (bus0.busy !== 2'b10) begin bad++; $display("FAIL rst_busy_pre got=%b want=10", bus0.busy); end
    total++; if (bus0.pwm !== 2'b11) begin bad++; $display("FAIL rst_pwm_pre got=%b want=11", bus0.pwm); end
    total++; if (bus0.at_up !== 2'b11) begin bad++; $display("FAIL rst_at_up_pre got=%b want=11", bus0.at_up); end
    repeat (15) step();
    d0 = dc0[1];
    reset = 1'b1;
    #1;
    total++; if (bus0.busy !== 2'b00) begin bad++; $display("FAIL rst_busy got=%b want=00", bus0.busy); end
    total++; if (bus0.pwm !== 2'b00) begin bad++; $display("FAIL rst_pwm got=%b want=00", bus0.pwm); end
    total++; if (bus0.at_up !== 2'b00) begin bad++; $display("FAIL rst_at_up got=%b want=00", bus0.at_up); end
    total++; if (bus0.done !== 2'b00) begin bad++; $display("FAIL rst_done got=%b want=00", bus0.done); end
    repeat (3) step();
    total++; if (dc0[1] !== d0) begin bad++; $display("FAIL rst_no_done got=%0d want=%0d", dc0[1], d0); end
    reset = 1'b0;
    repeat (2) step();
    total++; if (bus0.busy !== 2'b00) begin bad++; $display("FAIL rst_redrive_early got=%b want=00", bus0.busy); end
    step();
    total++; if (bus0.busy !== 2'b11) begin bad++; $display("FAIL rst_redrive got=%b want=11", bus0.busy); end
    for (int i = 0; i < 80 && bus0.done == 2'b00; i++) step();
    total++; if (bus0.done !== 2'b11) begin bad++; $display("FAIL rst_redrive_done got=%b want=11", bus0.done); end
    total++; if (bus0.at_up !== 2'b11) begin bad++; $display("FAIL rst_redrive_at_up got=%b want=11", bus0.at_up); end
  endtask

  initial begin
    test_reset();
    test_up_drive();
    test_repeat_level();
    test_reversal();
    test_two_channels();
    test_reset_mid_drive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
